instr_mem_server: RTL and testbench
===================================

Name: instr_mem_server

Overview:
- Instruction-memory responder on the fetch interface: it serves the combinational instruction word `ins` for the word-indexed fetch address `addr`.
- A byte-stream program loader with a valid/ready handshake fills the memory.
- While a load is pending or in progress, it holds the fetch stage through `halt_f`.
- It sits beside the fetch stage and is the only writer of instruction storage.

Parameters:
- AW, 10, address width of the storage; DEPTH = 2^AW words.
- NOP_WORD, 32'h0000_0000, word returned for out-of-range fetches.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- addr  in  32  fetch word address; PC increments by 1 per instruction.
- ins  out  32  instruction at `addr`; combinational read.
- halt_f  out  1  1 = fetch must hold PC and its pipeline latch.
- ld_start  in  1  single-cycle pulse that begins a (re)load.
- ld_valid  in  1  `ld_byte` is valid.
- ld_ready  out  1  loader accepts a byte this cycle.
- ld_byte  in  8  program byte, big-endian within each word.
- ld_last  in  1  qualifies the final byte of the image.
- ld_count  out  AW+1  number of words written by the current or most recent load.
- ld_err  out  1  sticky overflow flag; image exceeded DEPTH words.

Behaviour:
- States: WAIT (0), LOAD (1), RUN (2). Reset puts the block in WAIT.
- Reset values: halt_f=1, ld_ready=0, ld_count=0, ld_err=0, byte index=0, word pointer=0, assembly register=0.
- Storage contents are not cleared by reset.
- WAIT:
  - halt_f=1, ld_ready=0; ld_valid is ignored.
  - ld_start → LOAD; clears ld_count, ld_err, the byte index and the word pointer.
- LOAD:
  - halt_f=1, ld_ready=1. A byte transfers when ld_valid && ld_ready.
  - Byte k of a word (k = 0..3) goes to bits [31-8k -: 8] of the assembly register.
  - On byte k=3, the assembled word is written at the word pointer on the same edge. The pointer then increments and ld_count increments.
  - ld_last on byte k<3: the word is written with the unreceived low bytes forced to 0, then the block enters RUN.
  - ld_last on byte k=3: the word is written normally, then the block enters RUN.
  - ld_start while in LOAD is ignored.
- Overflow: a word completing while the pointer equals DEPTH is not written.
  - ld_err is set, and ld_count saturates at DEPTH.
  - The loader keeps consuming bytes until ld_last.
- RUN:
  - halt_f=0, ld_ready=0.
  - ld_start → LOAD, which reinitialises as in WAIT; halt_f rises on the next edge.
- Read path:
  - ins = mem[addr[AW-1:0]] when addr[31:AW]==0; otherwise ins = NOP_WORD.
  - The read is valid in every state.
  - A same-cycle write to the read address returns the old word; the new word is visible after the edge.
- Reset mid-load: asynchronous return to WAIT with all reset values. Words already written remain in storage.
- Latency:
  - Read: 0 cycles.
  - A word is readable 1 cycle after its completing byte.
  - halt_f falls on the edge that accepts the ld_last byte.

Decomposition:
- Shared package holds:
  - State encoding (WAIT/LOAD/RUN).
  - NOP_WORD default.
  - Opcode constants BEQZ=6'b001100 and BNEQZ=6'b001101, so benches can build branch images.
- Natural sub-module: `imem_array`, a DEPTH×32 storage with a combinational read port and a synchronous write port with enable. The FSM, byte assembler and counters stay in the top.

Test Plan:
1. Reset released, no ld_start for 10 cycles → halt_f=1, ld_ready=0; any ld_valid pulses produce no writes; ld_count=0.
2. ld_start, then 8 bytes 8C,00,00,01,30,00,00,02 with ld_last on the 8th → mem[0]=32'h8C000001, mem[1]=32'h30000002, ld_count=2; halt_f falls on the 8th-byte edge; addr=1 reads 32'h30000002.
3. 6 bytes AA,BB,CC,DD,11,22 with ld_last on the 6th → mem[1]=32'h11220000, ld_count=2, state RUN.
4. AW=2 build, 20 bytes with ld_last on the 20th → words 0–3 written, 5th word dropped; ld_err=1, ld_count=4; halt_f falls after the 20th byte.
5. addr=32'h0000_0400 with AW=10 → ins=NOP_WORD; addr=32'h3FF → ins=mem[1023].
6. rst_n asserted after byte 2 of word 1, then a reload via ld_start → state resets asynchronously; mem[0] is retained until overwritten; ld_count restarts at 0; ld_err=0.

Source files
------------

// File: rtl/instr_mem_server_pkg.sv
// Shared definitions for the instruction-memory server: state encoding,
// default fetch filler word, branch opcodes and the byte-placement helper.
package instr_mem_server_pkg;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  // Branch opcodes (bits [31:26] of an instruction word).
  localparam logic [5:0] OP_BEQZ  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;

  // Insert byte b as big-endian byte k of the word; bytes already received
  // (above k) are kept, bytes not yet received (below k) read as zero so a
  // word cut short by ld_last is zero-padded without extra logic.
  function automatic logic [31:0] place_byte(input logic [31:0] acc,
                                             input logic [1:0]  k,
                                             input logic [7:0]  b);
    logic [31:0] w;
    case (k)
      2'd0:    w = {b, 24'h00_0000};
      2'd1:    w = {acc[31:24], b, 16'h0000};
      2'd2:    w = {acc[31:16], b, 8'h00};
      default: w = {acc[31:8], b};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_mem_server_imem_array.sv
// DEPTH x 32 instruction storage: combinational read, synchronous write.
// Contents are intentionally not reset so a reset keeps the loaded image.
module imem_array #(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [2**AW];

  // Write port: the new word becomes visible to the read port after the edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_server.sv
// Instruction-memory server: serves fetch reads combinationally and fills
// the storage from a big-endian byte stream, holding fetch while loading.
module instr_mem_server
  import instr_mem_server_pkg::*;
#(
  parameter int          AW       = 10,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   addr,
  output logic [31:0]   ins,
  output logic          halt_f,
  input  logic          ld_start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  output logic [AW:0]   ld_count,
  output logic          ld_err
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_e      state_q;
  logic [1:0]  idx_q;
  logic [AW:0] ptr_q;     // word pointer; also the written-word count
  logic [31:0] asm_q;
  logic        err_q;
  logic        halt_q;
  logic        ready_q;

  logic        accept_s;
  logic        word_done_s;
  logic        room_s;
  logic        we_s;
  logic [31:0] word_s;
  logic [31:0] rdata_s;
  logic        in_range_s;

  // Byte acceptance and word-completion decode.
  always_comb begin
    accept_s    = ld_valid && ready_q;
    word_s      = place_byte(asm_q, idx_q, ld_byte);
    word_done_s = accept_s && ((idx_q == 2'd3) || ld_last);
    room_s      = (ptr_q != DEPTH);
    we_s        = word_done_s && room_s;
  end

  imem_array #(.AW(AW)) u_array (
    .clk_i   (clk),
    .we_i    (we_s),
    .waddr_i (ptr_q[AW-1:0]),
    .wdata_i (word_s),
    .raddr_i (addr[AW-1:0]),
    .rdata_o (rdata_s)
  );

  // Fetch read: addresses beyond the storage return the filler word.
  always_comb begin
    in_range_s = (addr[31:AW] == '0);
    if (in_range_s) begin
      ins = rdata_s;
    end else begin
      ins = NOP_WORD;
    end
  end

  // Loader FSM, byte assembler, pointer/count and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      idx_q   <= 2'd0;
      ptr_q   <= '0;
      asm_q   <= 32'h0000_0000;
      err_q   <= 1'b0;
      halt_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT, RUN: begin
          if (ld_start) begin
            state_q <= LOAD;
            idx_q   <= 2'd0;
            ptr_q   <= '0;
            asm_q   <= 32'h0000_0000;
            err_q   <= 1'b0;
            halt_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (accept_s) begin
            asm_q <= word_s;
            idx_q <= idx_q + 2'd1;
            if (word_done_s) begin
              idx_q <= 2'd0;
              if (room_s) begin
                ptr_q <= ptr_q + (AW+1)'(1);
              end else begin
                err_q <= 1'b1;
              end
            end
            if (ld_last) begin
              state_q <= RUN;
              halt_q  <= 1'b0;
              ready_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= WAIT;
          halt_q  <= 1'b1;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign halt_f   = halt_q;
  assign ld_ready = ready_q;
  assign ld_count = ptr_q;
  assign ld_err   = err_q;

endmodule

// File: tb/tb_instr_mem_server.sv
// Bench for instr_mem_server: a byte-stream program model checked every
// cycle against the AW=10 instance, plus literal checks on both instances.
module tb_instr_mem_server;
  import instr_mem_server_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] addr, addr2;
  logic [31:0] ins, ins2;
  logic        halt_f, halt_f2;
  logic        ld_start, ld_valid, ld_last;
  logic        ld_ready, ld_ready2;
  logic [7:0]  ld_byte;
  logic [10:0] ld_count;
  logic [2:0]  ld_count2;
  logic        ld_err, ld_err2;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // behavioural model state
  logic [31:0] m_mem   [1024];
  bit          m_known [1024];
  logic [7:0]  m_buf   [4];
  int          m_nb, m_cnt;
  bit          m_err, m_loading, m_ran;

  instr_mem_server #(.AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .ins(ins), .halt_f(halt_f),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_count(ld_count), .ld_err(ld_err)
  );

  instr_mem_server #(.AW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .addr(addr2), .ins(ins2), .halt_f(halt_f2),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_ready(ld_ready2),
    .ld_byte(ld_byte), .ld_last(ld_last), .ld_count(ld_count2), .ld_err(ld_err2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b0; m_ran = 1'b0; m_cnt = 0; m_err = 1'b0; m_nb = 0;
  endtask

  // One clock edge of the program-loader rules, using the inputs seen at the edge.
  task automatic model_step();
    logic [31:0] w;
    if (!rst_n) begin
      model_reset();
    end else if (!m_loading) begin
      if (ld_start) begin
        m_loading = 1'b1; m_cnt = 0; m_err = 1'b0; m_nb = 0;
      end
    end else if (ld_valid) begin
      m_buf[m_nb] = ld_byte;
      m_nb++;
      if (m_nb == 4 || ld_last) begin
        w = 32'h0;
        for (int i = 0; i < m_nb; i++) w[31-8*i -: 8] = m_buf[i];
        if (m_cnt < 1024) begin
          m_mem[m_cnt] = w; m_known[m_cnt] = 1'b1; m_cnt++;
        end else begin
          m_err = 1'b1;
        end
        m_nb = 0;
      end
      if (ld_last) begin
        m_loading = 1'b0; m_ran = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic start();
    ld_start = 1'b1; tick(); ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit last);
    ld_valid = 1'b1; ld_byte = b; ld_last = last;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  // Per-cycle comparison of the AW=10 instance against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("halt_f", {31'd0, halt_f}, {31'd0, (!m_ran || m_loading)});
      chk("ld_ready", {31'd0, ld_ready}, {31'd0, m_loading});
      chk("ld_count", {21'd0, ld_count}, m_cnt);
      chk("ld_err", {31'd0, ld_err}, {31'd0, m_err});
      if (addr[31:10] != 22'd0) chk("ins_nop", ins, NOP_WORD_DEF);
      else if (m_known[addr[9:0]]) chk("ins", ins, m_mem[addr[9:0]]);
    end
  end

  initial begin
    for (int i = 0; i < 1024; i++) m_known[i] = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_last = 1'b0; ld_byte = 8'h00;
    addr = 32'h0; addr2 = 32'h0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_on = 1'b1;
    chk("rst_halt", {31'd0, halt_f}, 32'd1);
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_count", {21'd0, ld_count}, 32'd0);
    chk("rst_err", {31'd0, ld_err}, 32'd0);

    // 1: WAIT ignores ld_valid
    for (int i = 0; i < 10; i++) begin
      ld_valid = i[0]; ld_byte = 8'hEE; tick();
    end
    ld_valid = 1'b0;
    chk("wait_count", {21'd0, ld_count}, 32'd0);
    chk("wait_halt", {31'd0, halt_f}, 32'd1);

    // 2: two-word image, ld_start mid-load ignored
    start();
    send(8'h8C, 0); send(8'h00, 0); send(8'h00, 0); send(8'h01, 0);
    ld_start = 1'b1; tick(); ld_start = 1'b0;
    send(8'h30, 0); send(8'h00, 0); send(8'h00, 0);
    chk("t2_halt_before", {31'd0, halt_f}, 32'd1);
    send(8'h02, 1);
    chk("t2_halt_after", {31'd0, halt_f}, 32'd0);
    chk("t2_count", {21'd0, ld_count}, 32'd2);
    addr = 32'd1; #1;
    chk("t2_mem1", ins, 32'h3000_0002);
    chk("t2_beqz", {26'd0, ins[31:26]}, {26'd0, OP_BEQZ});
    addr = 32'd0; #1;
    chk("t2_mem0", ins, 32'h8C00_0001);

    // 3: partial final word is zero-padded
    start();
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    send(8'h11, 0); send(8'h22, 1);
    addr = 32'd1; #1;
    chk("t3_mem1", ins, 32'h1122_0000);
    chk("t3_count", {21'd0, ld_count}, 32'd2);
    chk("t3_run", {31'd0, halt_f}, 32'd0);

    // 4: 20 bytes overflow the AW=2 instance
    start();
    for (int j = 0; j < 20; j++) begin
      if (j == 19) chk("t4_halt2_before", {31'd0, halt_f2}, 32'd1);
      send(8'h10 + 8'(j), j == 19);
    end
    chk("t4_halt2_after", {31'd0, halt_f2}, 32'd0);
    chk("t4_err2", {31'd0, ld_err2}, 32'd1);
    chk("t4_count2", {29'd0, ld_count2}, 32'd4);
    chk("t4_count1", {21'd0, ld_count}, 32'd5);
    chk("t4_err1", {31'd0, ld_err}, 32'd0);
    addr2 = 32'd3; #1;
    chk("t4_mem2_3", ins2, 32'h1C1D_1E1F);
    addr2 = 32'd0; #1;
    chk("t4_mem2_0", ins2, 32'h1011_1213);
    addr2 = 32'd4; #1;
    chk("t4_nop2", ins2, 32'h0000_0000);

    // 5: full image plus one word on AW=10, range checks
    start();
    for (int j = 0; j < 4100; j++) send(8'(j) ^ 8'h5A, j == 4099);
    chk("t5_err", {31'd0, ld_err}, 32'd1);
    chk("t5_count", {21'd0, ld_count}, 32'd1024);
    addr = 32'h0000_0400; #1;
    chk("t5_nop", ins, 32'h0000_0000);
    addr = 32'h0000_03FF; #1;
    chk("t5_last", ins, 32'hA6A7_A4A5);
    addr = 32'h8000_0000; #1;
    chk("t5_nop_hi", ins, 32'h0000_0000);
    addr = 32'd0; #1;

    // 6: reset mid-load, storage retained, reload
    start();
    send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 0);
    send(8'h01, 0); send(8'h02, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_halt", {31'd0, halt_f}, 32'd1);
    chk("t6_rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("t6_rst_count", {21'd0, ld_count}, 32'd0);
    chk("t6_rst_err", {31'd0, ld_err}, 32'd0);
    chk("t6_mem0_kept", ins, 32'hDEAD_BEEF);
    tick();
    rst_n = 1'b1;
    tick();
    start();
    send(8'h34, 0); send(8'h00, 0); send(8'h00, 0); send(8'h05, 1);
    #1;
    chk("t6_reload", ins, 32'h3400_0005);
    chk("t6_bneqz", {26'd0, ins[31:26]}, {26'd0, OP_BNEQZ});
    chk("t6_count", {21'd0, ld_count}, 32'd1);
    tick(); tick();

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
